// File: rtl/sc_lanebank_pkg.sv
// Shared definitions for the Frogger lane bank.
//   - Direction codes used on each lane's 2-bit direction field.
//   - lane_lsb(): bit offset of a lane's slice inside a packed lane bus.
// Optional feature macro: SC_LANEBANK_DRAIN_EN (enables DIR_DRAIN as a shift).
package sc_lanebank_pkg;

  localparam logic [1:0] DIR_HOLD  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DRAIN = 2'b11;

  // Lane idx occupies bits [idx*width +: width] of a packed bus.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sc_lanebank_lane.sv
// One playfield lane: rotating register, prescale counter and move flag.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   clear_ni         synchronous clear to INIT_VALUE (active low, all lanes)
//   load_i           this lane is selected for a load this cycle (already decoded)
//   load_data_i      value written on load
//   run_ni           0 = advance on ticks, 1 = paused
//   tick_i           one-cycle game tick
//   dir_i            direction code (see sc_lanebank_pkg)
//   period_i         lane moves once every period_i+1 qualifying ticks
//   lane_o           registered lane contents
//   moved_o          one-cycle pulse following a shift of the lane
// Optional feature macro: SC_LANEBANK_DRAIN_EN (code 11 = left shift inserting 0).
module sc_lanebank_lane
  import sc_lanebank_pkg::*;
#(
  parameter int unsigned          LANE_WIDTH     = 8,
  parameter int unsigned          PRESCALE_WIDTH = 4,
  parameter logic [LANE_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_ni,
  input  logic                      load_i,
  input  logic [LANE_WIDTH-1:0]     load_data_i,
  input  logic                      run_ni,
  input  logic                      tick_i,
  input  logic [1:0]                dir_i,
  input  logic [PRESCALE_WIDTH-1:0] period_i,
  output logic [LANE_WIDTH-1:0]     lane_o,
  output logic                      moved_o
);

  logic [LANE_WIDTH-1:0]     lane_q, lane_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      moved_q, moved_d;
  logic [LANE_WIDTH-1:0]     shifted;
  logic                      dir_active;
  logic                      step_en;

  always_comb begin
    shifted    = lane_q;
    dir_active = 1'b0;
    case (dir_i)
      DIR_LEFT: begin
        shifted    = {lane_q[LANE_WIDTH-2:0], lane_q[LANE_WIDTH-1]};
        dir_active = 1'b1;
      end
      DIR_RIGHT: begin
        shifted    = {lane_q[0], lane_q[LANE_WIDTH-1:1]};
        dir_active = 1'b1;
      end
`ifdef SC_LANEBANK_DRAIN_EN
      DIR_DRAIN: begin
        shifted    = {lane_q[LANE_WIDTH-2:0], 1'b0};
        dir_active = 1'b1;
      end
`endif
      default: begin
        shifted    = lane_q;
        dir_active = 1'b0;
      end
    endcase
  end

  assign step_en = !run_ni && tick_i && dir_active;

  always_comb begin
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    moved_d = 1'b0;
    if (!clear_ni) begin
      lane_d = INIT_VALUE;
      cnt_d  = '0;
    end else if (load_i) begin
      lane_d = load_data_i;
      cnt_d  = '0;
    end else if (step_en) begin
      // Live period compare; a counter above a newly lowered period simply
      // wraps through all-ones to zero without producing a move.
      if (cnt_q == period_i) begin
        cnt_d   = '0;
        lane_d  = shifted;
`ifdef SC_LANEBANK_DRAIN_EN
        moved_d = (dir_i == DIR_DRAIN) ? (shifted != lane_q) : 1'b1;
`else
        moved_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      cnt_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      moved_q <= moved_d;
    end
  end

  assign lane_o  = lane_q;
  assign moved_o = moved_q;

endmodule

// File: rtl/sc_reg_lanebank.sv
// Multi-lane background register bank for the Frogger playfield.
// Each lane rotates at its own prescaled rate of the shared game tick.
// Ports:
//   SC_RegLANEBANK_CLOCK_50          system clock
//   SC_RegLANEBANK_RESET_InHigh      asynchronous reset, active high (lanes -> 0)
//   SC_RegLANEBANK_clear_InLow       synchronous clear of all lanes to INIT_PATTERN
//   SC_RegLANEBANK_load_InLow        synchronous load of the selected lane
//   SC_RegLANEBANK_laneselect_In     lane index for the load
//   SC_RegLANEBANK_data_InBUS        load data
//   SC_RegLANEBANK_run_InLow         0 = advance on ticks, 1 = paused
//   SC_RegLANEBANK_tick_In           one-cycle game tick
//   SC_RegLANEBANK_direction_InBUS   2-bit direction code per lane
//   SC_RegLANEBANK_period_InBUS      per-lane period P (move every P+1 ticks)
//   SC_RegLANEBANK_data_OutBUS       packed lane registers
//   SC_RegLANEBANK_moved_OutBUS      per-lane move pulse
// Optional feature macro: SC_LANEBANK_DRAIN_EN (direction 11 drains the lane).
module sc_reg_lanebank
  import sc_lanebank_pkg::*;
#(
  parameter int unsigned                           LANE_WIDTH     = 8,
  parameter int unsigned                           LANE_COUNT     = 4,
  parameter int unsigned                           PRESCALE_WIDTH = 4,
  parameter logic [LANE_COUNT*LANE_WIDTH-1:0]      INIT_PATTERN   = '0,
  parameter int unsigned                           SEL_WIDTH      =
      (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1
) (
  input  logic                                SC_RegLANEBANK_CLOCK_50,
  input  logic                                SC_RegLANEBANK_RESET_InHigh,
  input  logic                                SC_RegLANEBANK_clear_InLow,
  input  logic                                SC_RegLANEBANK_load_InLow,
  input  logic [SEL_WIDTH-1:0]                SC_RegLANEBANK_laneselect_In,
  input  logic [LANE_WIDTH-1:0]               SC_RegLANEBANK_data_InBUS,
  input  logic                                SC_RegLANEBANK_run_InLow,
  input  logic                                SC_RegLANEBANK_tick_In,
  input  logic [2*LANE_COUNT-1:0]             SC_RegLANEBANK_direction_InBUS,
  input  logic [PRESCALE_WIDTH*LANE_COUNT-1:0] SC_RegLANEBANK_period_InBUS,
  output logic [LANE_WIDTH*LANE_COUNT-1:0]    SC_RegLANEBANK_data_OutBUS,
  output logic [LANE_COUNT-1:0]               SC_RegLANEBANK_moved_OutBUS
);

  for (genvar i = 0; i < LANE_COUNT; i++) begin : g_lane
    logic load_sel;

    // Out-of-range selects match no lane, so the load is dropped.
    assign load_sel = !SC_RegLANEBANK_load_InLow &&
                      (SC_RegLANEBANK_laneselect_In == SEL_WIDTH'(i));

    sc_lanebank_lane #(
      .LANE_WIDTH     (LANE_WIDTH),
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .INIT_VALUE     (INIT_PATTERN[lane_lsb(i, LANE_WIDTH) +: LANE_WIDTH])
    ) u_lane (
      .clk_i       (SC_RegLANEBANK_CLOCK_50),
      .rst_i       (SC_RegLANEBANK_RESET_InHigh),
      .clear_ni    (SC_RegLANEBANK_clear_InLow),
      .load_i      (load_sel),
      .load_data_i (SC_RegLANEBANK_data_InBUS),
      .run_ni      (SC_RegLANEBANK_run_InLow),
      .tick_i      (SC_RegLANEBANK_tick_In),
      .dir_i       (SC_RegLANEBANK_direction_InBUS[lane_lsb(i, 2) +: 2]),
      .period_i    (SC_RegLANEBANK_period_InBUS[lane_lsb(i, PRESCALE_WIDTH) +: PRESCALE_WIDTH]),
      .lane_o      (SC_RegLANEBANK_data_OutBUS[lane_lsb(i, LANE_WIDTH) +: LANE_WIDTH]),
      .moved_o     (SC_RegLANEBANK_moved_OutBUS[i])
    );
  end

endmodule

// File: tb/tb_sc_reg_lanebank.sv
// Directed bench for sc_reg_lanebank with an expectation queue.
// Honours SC_LANEBANK_DRAIN_EN when checking direction code 11.
module tb_sc_reg_lanebank;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_n, load_n, run_n, tick;
  logic [1:0]  sel;
  logic [7:0]  din;
  logic [7:0]  dir;
  logic [15:0] period;
  logic [31:0] dout;
  logic [3:0]  moved;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_data_q[$];
  logic [3:0]  exp_mov_q[$];
  string       tag_q[$];
  logic [7:0]  l [4];

  always #5 clk = ~clk;

  sc_reg_lanebank #(
    .LANE_WIDTH     (8),
    .LANE_COUNT     (4),
    .PRESCALE_WIDTH (4),
    .INIT_PATTERN   (32'hF0F0_0F0F)
  ) dut (
    .SC_RegLANEBANK_CLOCK_50        (clk),
    .SC_RegLANEBANK_RESET_InHigh    (rst),
    .SC_RegLANEBANK_clear_InLow     (clear_n),
    .SC_RegLANEBANK_load_InLow      (load_n),
    .SC_RegLANEBANK_laneselect_In   (sel),
    .SC_RegLANEBANK_data_InBUS      (din),
    .SC_RegLANEBANK_run_InLow       (run_n),
    .SC_RegLANEBANK_tick_In         (tick),
    .SC_RegLANEBANK_direction_InBUS (dir),
    .SC_RegLANEBANK_period_InBUS    (period),
    .SC_RegLANEBANK_data_OutBUS     (dout),
    .SC_RegLANEBANK_moved_OutBUS    (moved)
  );

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

  function automatic logic [31:0] pack_lanes();
    return {l[3], l[2], l[1], l[0]};
  endfunction

  task automatic push(input string t, input logic [31:0] d, input logic [3:0] m);
    tag_q.push_back(t);
    exp_data_q.push_back(d);
    exp_mov_q.push_back(m);
  endtask

  task automatic check_now();
    string       t;
    logic [31:0] ed;
    logic [3:0]  em;
    if (exp_data_q.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty: got no expectation, need one");
    end else begin
      t  = tag_q.pop_front();
      ed = exp_data_q.pop_front();
      em = exp_mov_q.pop_front();
      n_checks++;
      assert (dout === ed) n_pass++;
      else $error("FAIL %s data: got %h expected %h", t, dout, ed);
      n_checks++;
      assert (moved === em) n_pass++;
      else $error("FAIL %s moved: got %b expected %b", t, moved, em);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    rst = 1'b1; clear_n = 1'b1; load_n = 1'b1; run_n = 1'b1; tick = 1'b0;
    sel = 2'd0; din = 8'h00; dir = 8'h00; period = 16'h0000;

    // Reset state, before any clock edge.
    #1;
    push("reset", 32'h0, 4'b0);
    check_now();
    #10;
    rst = 1'b0;

    // Make a lane nonzero, then reset asynchronously mid-cycle.
    @(posedge clk); #1;
    load_n = 1'b0; sel = 2'd0; din = 8'h5A;
    push("load_pre_reset", 32'h0000_005A, 4'b0);
    step();
    load_n = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    push("async_reset", 32'h0, 4'b0);
    check_now();
    #2;
    rst = 1'b0;

    // Clear to INIT_PATTERN.
    @(posedge clk); #1;
    clear_n = 1'b0;
    push("clear", 32'hF0F0_0F0F, 4'b0);
    step();
    clear_n = 1'b1;
    l[3] = 8'hF0; l[2] = 8'hF0; l[1] = 8'h0F; l[0] = 8'h0F;

    // Rate test: lane0 period 2, lane1 period 0, both rotate left.
    load_n = 1'b0; sel = 2'd0; din = 8'h81; l[0] = 8'h81;
    push("load_l0", pack_lanes(), 4'b0);
    step();
    sel = 2'd1; din = 8'h01; l[1] = 8'h01;
    push("load_l1", pack_lanes(), 4'b0);
    step();
    load_n = 1'b1;
    dir = 8'b00_00_01_01; period = 16'h0002; run_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick = 1'b1;
      if (k % 3 == 0) l[0] = rotl(l[0]);
      l[1] = rotl(l[1]);
      push($sformatf("rate_tick%0d", k), pack_lanes(), {2'b00, 1'b1, (k % 3 == 0)});
      step();
      tick = 1'b0;
      push($sformatf("rate_idle%0d", k), pack_lanes(), 4'b0);
      step();
    end
    push("rate_final", 32'hF0F0_020C, 4'b0);
    step();

    // Right rotate with wrap on lane2.
    load_n = 1'b0; sel = 2'd2; din = 8'h01; l[2] = 8'h01;
    push("load_l2", pack_lanes(), 4'b0);
    step();
    load_n = 1'b1; dir = 8'b00_10_00_00; period = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      tick = 1'b1;
      l[2] = rotr(l[2]);
      if (k == 1) push("rotr_first", 32'hF080_020C, 4'b0100);
      else        push($sformatf("rotr_tick%0d", k), pack_lanes(), 4'b0100);
      step();
    end
    tick = 1'b0;
    push("rotr_final", 32'hF001_020C, 4'b0);
    step();

    // Load priority: lane1 period 1 armed so a missed load would move it.
    dir = 8'b01_00_01_00; period = 16'h0010; tick = 1'b1;
    l[3] = rotl(l[3]);
    push("prio_arm", 32'hE101_020C, 4'b1000);
    step();
    load_n = 1'b0; sel = 2'd1; din = 8'hAA;
    push("prio_load", 32'hC301_AA0C, 4'b1000);
    step();
    load_n = 1'b1;
    push("prio_count", 32'h8701_AA0C, 4'b1000);
    step();
    push("prio_move", 32'h0F01_550C, 4'b1010);
    step();
    clear_n = 1'b0; load_n = 1'b0;
    push("prio_clear", 32'hF0F0_0F0F, 4'b0);
    step();
    clear_n = 1'b1; load_n = 1'b1; tick = 1'b0;

    // Pause / hold freeze the counter without resetting it.
    dir = 8'b00_00_00_01; period = 16'h0002; tick = 1'b1;
    push("pause_t1", 32'hF0F0_0F0F, 4'b0);
    step();
    run_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push("paused", 32'hF0F0_0F0F, 4'b0);
      step();
    end
    run_n = 1'b0; dir = 8'h00;
    for (int k = 0; k < 2; k++) begin
      push("hold_code", 32'hF0F0_0F0F, 4'b0);
      step();
    end
    dir = 8'b00_00_00_01;
    push("resume_t2", 32'hF0F0_0F0F, 4'b0);
    step();
    push("resume_move", 32'hF0F0_0F1E, 4'b0001);
    step();
    tick = 1'b0;

    // Direction code 11 on lane0.
    l[3] = 8'hF0; l[2] = 8'hF0; l[1] = 8'h0F;
    load_n = 1'b0; sel = 2'd0; din = 8'hFF; l[0] = 8'hFF;
    push("load_drain", pack_lanes(), 4'b0);
    step();
    load_n = 1'b1; dir = 8'b00_00_00_11; period = 16'h0000; tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
`ifdef SC_LANEBANK_DRAIN_EN
      l[0] = {l[0][6:0], 1'b0};
      push($sformatf("drain_tick%0d", k), pack_lanes(), {3'b000, (k <= 8)});
`else
      push($sformatf("drain_hold%0d", k), pack_lanes(), 4'b0);
`endif
      step();
    end
    tick = 1'b0;
`ifdef SC_LANEBANK_DRAIN_EN
    push("drain_final", 32'hF0F0_0F00, 4'b0);
`else
    push("drain_final", 32'hF0F0_0FFF, 4'b0);
`endif
    step();

    if (exp_data_q.size() != 0) begin
      n_checks++;
      $error("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_data_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_reg_lanebank.md
Name: sc_reg_lanebank

Overview:
- Multi-lane background register bank for the Frogger playfield.
- Holds LANE_COUNT independent rotating lanes, each LANE_WIDTH bits wide.
- Each lane rotates left or right at its own programmable rate, derived from a shared game-tick pulse.
- Sits between the level/speed controller and the matrix/VGA renderer; it replaces per-lane single-rate background registers.

Parameters:
- LANE_WIDTH, 8, bits per lane.
- LANE_COUNT, 4, number of lanes.
- PRESCALE_WIDTH, 4, width of each lane's period field and internal tick counter.
- INIT_PATTERN, {LANE_COUNT*LANE_WIDTH{1'b0}}, value applied to all lanes by clear_InLow; lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH].
- SEL_WIDTH, $clog2(LANE_COUNT) (minimum 1), width of the lane select.

Ports:
- SC_RegLANEBANK_CLOCK_50  in  1  system clock.
- SC_RegLANEBANK_RESET_InHigh  in  1  asynchronous reset, active high.
- SC_RegLANEBANK_clear_InLow  in  1  synchronous clear of all lanes to INIT_PATTERN.
- SC_RegLANEBANK_load_InLow  in  1  synchronous load of the selected lane.
- SC_RegLANEBANK_laneselect_In  in  SEL_WIDTH  lane index for the load.
- SC_RegLANEBANK_data_InBUS  in  LANE_WIDTH  load data.
- SC_RegLANEBANK_run_InLow  in  1  0 = lanes advance on ticks; 1 = paused.
- SC_RegLANEBANK_tick_In  in  1  one-cycle game-tick pulse.
- SC_RegLANEBANK_direction_InBUS  in  2*LANE_COUNT  per-lane code: 01 = rotate left, 10 = rotate right, 00 = hold, 11 = hold (see Optional Feature).
- SC_RegLANEBANK_period_InBUS  in  PRESCALE_WIDTH*LANE_COUNT  per-lane period P; the lane moves once every P+1 ticks.
- SC_RegLANEBANK_data_OutBUS  out  LANE_WIDTH*LANE_COUNT  registered lane contents.
- SC_RegLANEBANK_moved_OutBUS  out  LANE_COUNT  per-lane one-cycle pulse, asserted the cycle after that lane's contents changed by a shift.

Behaviour:
- Reset (asynchronous, active high):
  - All lanes = 0 (not INIT_PATTERN).
  - All tick counters = 0.
  - moved_OutBUS = 0.
  - Reset takes effect mid-operation with no further clock edge needed.
- Per lane i, each rising edge, in priority order:
  1. clear_InLow = 0: lane = INIT_PATTERN slice; counter = 0; no move pulse. Applies to all lanes.
  2. load_InLow = 0 and laneselect = i: lane = data_InBUS; counter = 0; no move pulse. Unselected lanes continue normal operation in the same cycle.
  3. run_InLow = 0, tick_In = 1, direction code in {01, 10}:
     - If counter == period[i]: counter = 0; lane rotates by one bit; moved[i] = 1 next cycle.
     - Otherwise: counter = counter + 1.
  4. All other cases: lane and counter hold.
- Rotate-left result = {lane[W-2:0], lane[W-1]}; rotate-right result = {lane[0], lane[W-1:1]}.
- Period 0: the lane moves on every tick. Period all-ones: the lane moves every 2^PRESCALE_WIDTH ticks.
- Period change mid-count: comparison uses the live period_InBUS value. If the counter already exceeds the new period, counting continues to counter wrap (all-ones to 0); that wrap does not generate a move. No saturation.
- Hold code or pause: counter is frozen, not reset.
- laneselect >= LANE_COUNT: the load is ignored by every lane.
- Latency: input to data_OutBUS is one clock. data_OutBUS is driven directly from the lane registers, with no extra logic.
- moved_OutBUS is registered; it is high for exactly one cycle per move.

Optional Feature:
- Macro: SC_LANEBANK_DRAIN_EN.
- Defined: direction code 11 = logical left shift inserting 0 at bit 0, at the same prescaled rate. moved[i] pulses only if the lane value actually changed; an all-zero lane produces no pulse.
- Undefined: code 11 = hold, identical to code 00.

Decomposition:
- Shared package (sc_lanebank_pkg): direction code constants DIR_HOLD=2'b00, DIR_LEFT=2'b01, DIR_RIGHT=2'b10, DIR_DRAIN=2'b11; a lane-slice index helper.
- Sub-module sc_lanebank_lane: one lane register plus its prescale counter and move flag. Instantiated LANE_COUNT times by a generate loop. The top level handles only select decode and bus packing.

Test Plan:
- Reset then clear: assert reset mid-run with lanes nonzero -> all lanes 0 immediately. Then clear_InLow = 0 with INIT_PATTERN = 32'hF0F0_0F0F -> data_OutBUS = 32'hF0F0_0F0F next cycle, moved = 0.
- Rate: lane0 = 8'b1000_0001, dir = 01, period = 2, 9 ticks -> 3 moves, lane0 = 8'b0000_1100, moved[0] pulses on ticks 3, 6, 9. Lane1 with period 0 moves on all 9 ticks.
- Right rotate wrap: lane2 = 8'h01, dir = 10, period 0, 1 tick -> 8'h80; 8 ticks total -> 8'h01.
- Load priority: same cycle load lane1 = 8'hAA while lane1 and lane3 tick-move -> lane1 = 8'hAA, counter[1] = 0, moved[1] = 0; lane3 moves normally. With clear also low -> all lanes = INIT_PATTERN.
- Pause/hold: run_InLow = 1 for 5 ticks, then 0 -> counters resume from their frozen values; no moves while paused.
- DRAIN_EN: lane0 = 8'hFF, dir = 11, period 0 -> after 8 ticks lane0 = 8'h00, moved[0] pulsed 8 times, and no pulse on tick 9. Without the macro, lane0 stays 8'hFF.
